led_uart_tx: RTL and testbench
==============================

# led_uart_tx

Byte-serial debug transmitter that drives the board's single `LED` pin as an 8N1 asynchronous serial line. It sits beside the stack processor in `top` and accepts bytes from the processor's output port through a valid/ready handshake. It buffers them in a small FIFO and shifts them out LSB-first. The bench that watches `LED` decodes the pin as a UART receiver and checks processor output without probing internal state.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Legal range is ≥2. Use 4 in simulation (40 ns `CLK` gives 160 ns/bit).
- `FIFO_DEPTH`, default 4: byte entries in the transmit FIFO. Must be a power of two, ≥2.
- `CLK` input, 1 bit: the single clock. All logic samples on the rising edge.
- `RST` input, 1 bit: asynchronous, active-high reset.
- `data_in` input, 8 bits: byte to transmit.
- `data_valid` input, 1 bit: `data_in` is offered this cycle.
- `data_ready` output, 1 bit: the FIFO can accept a byte. Equals !full.
- `LED` output, 1 bit: serial line. Idles high.
- `busy` output, 1 bit: high when the FSM is not in IDLE or the FIFO is not empty.

## Operation
- Push: a byte is written when `data_valid && data_ready` at a rising edge. `data_in` while `data_valid` is low is ignored.
- FIFO: circular buffer with wrapping read/write pointers and a count from 0 to `FIFO_DEPTH`.
  - full: count == `FIFO_DEPTH`.
  - empty: count == 0.
  - Push and pop in the same cycle leave count unchanged.
  - Push while full cannot occur because `data_ready` is low.
- The FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: `LED`=1. If the FIFO is not empty, pop the head into an 8-bit shift register and go to START.
  - START: `LED`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `LED` = shift[0] for `CLKS_PER_BIT` cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `LED`=1 for `CLKS_PER_BIT` cycles. At the end, if the FIFO is not empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Bit timer: counts 0..`CLKS_PER_BIT`-1, clears on every state entry, and has width clog2(`CLKS_PER_BIT`). Bit index width is 3.
- `LED` is registered and glitch-free. It is never driven from combinational decode.
- Reset values (asynchronous) are: state IDLE, `LED`=1, FIFO empty, pointers 0, timer 0, shift register 0.
  - Consequently `data_ready`=1 and `busy`=0 once `RST` deasserts.
  - Reset mid-frame aborts the frame: `LED` returns high immediately and the buffered bytes are discarded.

## Timing
- A push at edge N into an empty FIFO with the FSM in IDLE gives the following timeline:
  - edge N+1: the FSM pops the byte.
  - after edge N+1: `LED` falls to 0 (start bit).
- Frame length is exactly 10×`CLKS_PER_BIT` cycles: start, 8 data bits, stop.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `data_ready` is combinational from the count.
  - It deasserts in the cycle after the push that fills the FIFO.
  - It reasserts in the cycle after the FSM pops.
- A push into a full FIFO in the same cycle as a pop is not accepted, because `data_ready` was low.
- `busy` rises the cycle after the first push and falls the cycle after the final stop bit completes with the FIFO empty.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4 and a 40 ns clock.
- Reset: assert `RST` asynchronously mid-cycle. Required: `LED`=1, `data_ready`=1 and `busy`=0 immediately and for the whole reset period.
- Single byte: push 0xA5. Required: `LED` falls one cycle later. The bench samples mid-bit and decodes 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop) over 40 cycles, then `busy` falls.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles. Required: two 40-cycle frames with no idle cycle between them, decoded as 0x00 then 0xFF.
- Full FIFO: hold `data_valid` with bytes 0x01..0x06 from idle. Required:
  - 0x01 is popped immediately.
  - 0x02..0x05 fill the FIFO, and `data_ready` goes low.
  - 0x06 is accepted only after the next pop.
  - All six bytes emerge in order.
- Reset mid-frame: push 0x3C, assert `RST` during data bit 3, then release and push 0x81. Required: `LED` goes high at once, no remnant of 0x3C is sent, and 0x81 is decoded cleanly.
- Simultaneous push and pop: with the FIFO holding 1 byte, push on the exact cycle the FSM pops at the end of STOP. Required: the count stays at 1 and the order is preserved.

Source files
------------

// File: rtl/led_uart_tx.sv
// 8N1 serial transmitter on the LED pin, fed by a small byte FIFO.
// Bytes go out LSB-first; back-to-back frames have no idle gap.
module led_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       LED,
    output logic       busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          bit_end;

    assign full       = (count == (PW+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign data_ready = !full;
    assign busy       = (state != S_IDLE) || !empty;
    assign bit_end    = (timer == TW'(CLKS_PER_BIT - 1));
    assign push       = data_valid && !full;
    // The FSM takes the head either from idle or at the very end of a stop bit.
    assign pop        = !empty &&
                        ((state == S_IDLE) || (state == S_STOP && bit_end));

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            LED   <= 1'b1;
            timer <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            timer <= bit_end ? '0 : timer + TW'(1);
            case (state)
                S_IDLE: begin
                    LED   <= 1'b1;
                    timer <= '0;
                    if (!empty) begin
                        shift <= mem[rd_ptr];
                        state <= S_START;
                        LED   <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state <= S_DATA;
                        idx   <= '0;
                        LED   <= shift[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift <= shift >> 1;
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= S_STOP;
                            LED   <= 1'b1;
                        end else begin
                            LED <= shift[1];
                        end
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (!empty) begin
                            shift <= mem[rd_ptr];
                            state <= S_START;
                            LED   <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            LED   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    LED   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_led_uart_tx.sv
// Bench for led_uart_tx: a UART-receiver monitor decodes LED and
// compares each frame against a queue of expected bytes.
module tb_led_uart_tx;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       LED;
    logic       busy;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    logic [7:0] expq [$];
    int         starts [$];

    led_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .data_in(data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .LED(LED),
        .busy(busy)
    );

    always #20 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: start bit detected at its first cycle, bits sampled mid-bit.
    logic [9:0] bits;
    logic [7:0] exp_byte;
    bit         aborted;
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST && LED === 1'b0) begin
                starts.push_back(cyc);
                aborted = 1'b0;
                bits = '0;
                for (int off = 0; off < 40; off++) begin
                    if (off > 0) @(negedge CLK);
                    if (RST) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (off % 4 == 2) bits[off/4] = LED;
                end
                if (!aborted) begin
                    check("frame_expected", expq.size() > 0, 1);
                    if (expq.size() > 0) begin
                        exp_byte = expq.pop_front();
                        check("start_bit", bits[0], 1'b0);
                        check("data_byte", bits[8:1], exp_byte);
                        check("stop_bit", bits[9], 1'b1);
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit expect_out);
        data_in    = b;
        data_valid = 1'b1;
        if (expect_out) expq.push_back(b);
        @(posedge CLK); #1;
        data_valid = 1'b0;
    endtask

    task automatic wait_idle(string name);
        bit done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge CLK); #1;
            if (!busy && expq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check(name, done, 1'b1);
    endtask

    int n;
    bit ok;
    int acc [6];
    int s0;

    initial begin
        // Reset asserted mid-cycle
        #7 RST = 1'b1;
        #1;
        check("rst_led", LED, 1'b1);
        check("rst_ready", data_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        repeat (3) begin
            @(negedge CLK);
            check("rst_hold_led", LED, 1'b1);
            check("rst_hold_busy", busy, 1'b0);
        end
        @(posedge CLK); #10 RST = 1'b0;
        @(posedge CLK); #1;
        check("post_rst_ready", data_ready, 1'b1);
        check("post_rst_led", LED, 1'b1);

        // Single byte 0xA5
        push_byte(8'hA5, 1'b1);
        check("single_busy_rise", busy, 1'b1);
        check("single_led_before", LED, 1'b1);
        @(posedge CLK); #1;
        check("single_led_fall", LED, 1'b0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #1;
            n++;
            if (!busy) break;
        end
        check("single_busy_len", n, 40);
        wait_idle("single_idle");

        // Back-to-back 0x00, 0xFF
        starts.delete();
        push_byte(8'h00, 1'b1);
        push_byte(8'hFF, 1'b1);
        wait_idle("b2b_idle");
        check("b2b_frames", starts.size(), 2);
        if (starts.size() >= 2) check("b2b_gap", starts[1] - starts[0], 40);

        // Full FIFO: hold valid with 0x01..0x06
        data_valid = 1'b1;
        for (int b = 1; b <= 6; b++) begin
            data_in = 8'(b);
            expq.push_back(8'(b));
            for (int w = 0; w < 100; w++) begin
                ok = data_ready;
                @(posedge CLK); #1;
                if (ok) break;
            end
            acc[b-1] = cyc;
            if (b == 5) check("full_ready_low", data_ready, 1'b0);
        end
        data_valid = 1'b0;
        check("full_fill_time", acc[4] - acc[0], 4);
        check("full_sixth_time", acc[5] - acc[0], 42);
        wait_idle("full_idle");

        // Simultaneous push and pop with one byte buffered
        starts.delete();
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        repeat (39) @(posedge CLK);
        #1;
        check("sim_ready_pre", data_ready, 1'b1);
        push_byte(8'h33, 1'b1);
        check("sim_ready_post", data_ready, 1'b1);
        push_byte(8'h44, 1'b1);
        push_byte(8'h55, 1'b1);
        check("sim_ready_three", data_ready, 1'b1);
        push_byte(8'h66, 1'b1);
        check("sim_ready_full", data_ready, 1'b0);
        wait_idle("sim_idle");
        check("sim_frames", starts.size(), 6);
        if (starts.size() >= 3) check("sim_gap", starts[2] - starts[1], 40);

        // Reset during data bit 3 of 0x3C
        push_byte(8'h3C, 1'b0);
        repeat (16) @(posedge CLK);
        #10 RST = 1'b1;
        #1;
        check("midrst_led", LED, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", data_ready, 1'b1);
        repeat (2) begin
            @(negedge CLK);
            check("midrst_hold_led", LED, 1'b1);
        end
        @(posedge CLK); #15 RST = 1'b0;
        @(posedge CLK); #1;
        check("midrst_after_led", LED, 1'b1);
        check("midrst_after_busy", busy, 1'b0);
        s0 = starts.size();
        push_byte(8'h81, 1'b1);
        wait_idle("midrst_idle");
        check("midrst_frames", starts.size() - s0, 1);

        repeat (10) @(posedge CLK);
        check("queue_drained", expq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
